// File: rtl/spart_bus_sched.sv
// Owns the SPART 8-bit bus: loads the baud divisor after reset, then arbitrates
// RX reads (priority, burst-capped) against TX writes from the send FIFO.
module spart_bus_sched #(
    parameter logic [15:0] DIVISOR      = 16'h0145,
    parameter int          RX_BURST_MAX = 4,
    parameter int          TBR_LAT      = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [7:0] db_in,
    input  logic       rda,
    input  logic       tbr,
    input  logic       tx_empty,
    input  logic [7:0] tx_data,
    output logic       tx_pop,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       cfg_busy
);

    // state   | meaning
    // INIT_LO | next cycle drives divisor low byte
    // INIT_HI | next cycle drives divisor high byte
    // IDLE    | bus released; pick the next access
    // RX_RD   | next cycle reads the SPART data buffer
    // TX_WR   | next cycle writes the FIFO head to the SPART
    typedef enum logic [2:0] {
        INIT_LO = 3'd0,
        INIT_HI = 3'd1,
        IDLE    = 3'd2,
        RX_RD   = 3'd3,
        TX_WR   = 3'd4
    } state_t;

    localparam int BW = $clog2(RX_BURST_MAX + 1);
    localparam int HW = $clog2(TBR_LAT + 1);

    state_t        state;
    logic [BW-1:0] burst;
    logic [HW-1:0] holdoff;
    logic          rd_phase;
    logic          tx_ok;
    logic          burst_full;

    assign tx_ok      = ~tx_empty & tbr & (holdoff == '0);
    assign burst_full = (burst == BW'(RX_BURST_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT_LO;
            iorw     <= 1'b1;
            ioaddr   <= 2'b01;
            db_oe    <= 1'b0;
            db_out   <= 8'h00;
            tx_pop   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            cfg_busy <= 1'b1;
            burst    <= '0;
            holdoff  <= '0;
            rd_phase <= 1'b0;
        end else begin
            tx_pop   <= 1'b0;
            rx_valid <= 1'b0;
            rd_phase <= 1'b0;

            // The SPART drives the bus during the read cycle; capture at its end.
            if (rd_phase) begin
                rx_data  <= db_in;
                rx_valid <= 1'b1;
            end

            if (holdoff != '0)
                holdoff <= holdoff - 1'b1;

            case (state)
                INIT_LO: begin
                    iorw   <= 1'b0;
                    ioaddr <= 2'b10;
                    db_oe  <= 1'b1;
                    db_out <= DIVISOR[7:0];
                    state  <= INIT_HI;
                end
                INIT_HI: begin
                    iorw   <= 1'b0;
                    ioaddr <= 2'b11;
                    db_oe  <= 1'b1;
                    db_out <= DIVISOR[15:8];
                    state  <= IDLE;
                end
                IDLE: begin
                    iorw     <= 1'b1;
                    ioaddr   <= 2'b01;
                    db_oe    <= 1'b0;
                    cfg_busy <= 1'b0;
                    if (rda && !(tx_ok && burst_full)) begin
                        state <= RX_RD;
                        if (tx_ok)
                            burst <= burst + 1'b1;
                    end else if (tx_ok) begin
                        state <= TX_WR;
                        burst <= '0;
                    end else if (!rda) begin
                        burst <= '0;
                    end
                end
                RX_RD: begin
                    iorw     <= 1'b1;
                    ioaddr   <= 2'b00;
                    db_oe    <= 1'b0;
                    rd_phase <= 1'b1;
                    state    <= IDLE;
                end
                TX_WR: begin
                    iorw    <= 1'b0;
                    ioaddr  <= 2'b00;
                    db_oe   <= 1'b1;
                    db_out  <= tx_data;
                    tx_pop  <= ~tx_empty;
                    holdoff <= HW'(TBR_LAT);
                    state   <= IDLE;
                end
                default: begin
                    iorw   <= 1'b1;
                    ioaddr <= 2'b01;
                    db_oe  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_bus_sched.sv
// Scoreboard bench for spart_bus_sched: a SPART/FIFO model feeds the DUT, a
// negedge monitor checks every popped and received byte against queued values.
module tb_spart_bus_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] db_out;
    logic       db_oe;
    logic [7:0] db_in = 8'h00;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic       tx_empty;
    logic [7:0] tx_data;
    logic       tx_pop;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cfg_busy;

    spart_bus_sched dut (
        .clk(clk), .rst(rst), .iorw(iorw), .ioaddr(ioaddr), .db_out(db_out),
        .db_oe(db_oe), .db_in(db_in), .rda(rda), .tbr(tbr), .tx_empty(tx_empty),
        .tx_data(tx_data), .tx_pop(tx_pop), .rx_valid(rx_valid), .rx_data(rx_data),
        .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    logic [7:0] fifo_mem [0:63];
    int         rd_ptr = 0;
    int         wr_ptr = 0;
    logic [7:0] exp_tx [$];
    logic [7:0] exp_rx [$];
    byte        acc_kind [$];
    int         acc_cyc [$];
    logic [7:0] rx_pat = 8'h3C;

    assign tx_empty = (rd_ptr == wr_ptr);
    assign tx_data  = fifo_mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_pop && !tx_empty)
            rd_ptr <= rd_ptr + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] v);
        fifo_mem[wr_ptr[5:0]] = v;
        wr_ptr++;
        exp_tx.push_back(v);
    endtask

    // Monitor / SPART model: drives db_in during reads and scores bytes.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
            end
            if (tx_pop) begin
                check("pop_nonempty", {31'h0, tx_empty}, 0);
                check("pop_bus_write", {29'h0, db_oe, iorw, ioaddr[0]}, 32'h4);
                if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
                else check("tx_byte", {24'h0, db_out}, {24'h0, exp_tx.pop_front()});
            end
            if (db_oe && iorw) check("bus_contention", 1, 0);
            if (iorw && ioaddr == 2'b00) begin
                acc_kind.push_back("R");
                acc_cyc.push_back(cyc);
                db_in = rx_pat;
                exp_rx.push_back(rx_pat);
                rx_pat = rx_pat + 8'h13;
            end else if (!iorw && ioaddr == 2'b00) begin
                acc_kind.push_back("T");
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_init();
        tick();
        check("init_lo", {20'h0, iorw, db_oe, ioaddr, db_out}, {20'h0, 1'b0, 1'b1, 2'b10, 8'h45});
        check("init_lo_busy", {31'h0, cfg_busy}, 1);
        tick();
        check("init_hi", {20'h0, iorw, db_oe, ioaddr, db_out}, {20'h0, 1'b0, 1'b1, 2'b11, 8'h01});
        tick();
        check("init_idle", {28'h0, iorw, db_oe, ioaddr}, {28'h0, 1'b1, 1'b0, 2'b01});
        check("init_busy_low", {31'h0, cfg_busy}, 0);
    endtask

    function automatic int count_kind(input int base, input byte k);
        int n = 0;
        for (int i = base; i < acc_kind.size(); i++)
            if (acc_kind[i] == k) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int    base;
        int    t0;
        int    t1;
        bit    seen;
        string pat;

        // Reset state and divisor load
        rst = 1'b0;
        #12;
        check("rst_bus", {28'h0, iorw, db_oe, ioaddr}, {28'h0, 1'b1, 1'b0, 2'b01});
        check("rst_strobes", {29'h0, tx_pop, rx_valid, cfg_busy}, 32'h1);
        check("rst_rx_data", {24'h0, rx_data}, 0);
        @(negedge clk);
        rst = 1'b1;
        check_init();

        // Empty FIFO with tbr high: bus parks idle
        tbr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("empty_idle", {28'h0, iorw, tx_pop, ioaddr}, {28'h0, 1'b1, 1'b0, 2'b01});
        end

        // Two queued bytes: second write held off by tbr latency
        base = acc_kind.size();
        push_tx(8'hA5);
        push_tx(8'h5A);
        for (int i = 0; i < 60 && count_kind(base, "T") < 2; i++) tick();
        check("tx_two_writes", count_kind(base, "T"), 2);
        t0 = -1;
        t1 = -1;
        for (int i = base; i < acc_kind.size(); i++)
            if (acc_kind[i] == "T") begin
                if (t0 < 0) t0 = acc_cyc[i];
                else if (t1 < 0) t1 = acc_cyc[i];
            end
        // write, two masked idle cycles, decision idle, then the next write
        check("tx_holdoff_gap", t1 - t0, 4);
        tbr = 1'b0;
        repeat (5) tick();

        // Single RX
        base = acc_kind.size();
        rda = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (acc_kind.size() > base) seen = 1;
        end
        rda = 1'b0;
        check("rx_seen", {31'h0, seen}, 1);
        check("rx_db_oe_low", {31'h0, db_oe}, 0);
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick();
            if (rx_valid) seen = 1;
        end
        check("rx_valid_pulse", {31'h0, seen}, 1);
        check("rx_first_byte", {24'h0, rx_data}, 32'h3C);
        tick();
        check("rx_valid_single", {31'h0, rx_valid}, 0);
        check("rx_data_held", {24'h0, rx_data}, 32'h3C);
        repeat (3) tick();

        // Contention: RX priority with burst cap; the read right after a write
        // happens while tbr is still masked, so it does not count toward the burst.
        base = acc_kind.size();
        push_tx(8'h11);
        push_tx(8'h22);
        tbr = 1'b1;
        rda = 1'b1;
        pat = "RRRRTRRRRRT";
        for (int i = 0; i < 100 && acc_kind.size() < base + 11; i++) tick();
        rda = 1'b0;
        tbr = 1'b0;
        check("contention_len", (acc_kind.size() >= base + 11) ? 1 : 0, 1);
        for (int i = 0; i < 11; i++)
            if (base + i < acc_kind.size())
                check("contention_seq", {24'h0, acc_kind[base + i]}, {24'h0, pat[i]});
        repeat (6) tick();

        // Async reset during a TX write
        push_tx(8'hC3);
        tbr = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (tx_pop) seen = 1;
        end
        check("rst_tx_seen", {31'h0, seen}, 1);
        rst = 1'b0;
        #1;
        check("rst_async_oe_pop", {30'h0, db_oe, tx_pop}, 0);
        check("rst_async_bus", {29'h0, iorw, ioaddr}, {29'h0, 1'b1, 2'b01});
        // The aborted write did not pop, so the byte is owed again.
        exp_tx.push_front(8'hC3);
        @(negedge clk);
        rst = 1'b1;
        check_init();
        for (int i = 0; i < 20 && exp_tx.size() != 0; i++) tick();
        tbr = 1'b0;
        repeat (5) tick();
        check("tx_drained", exp_tx.size(), 0);
        check("rx_drained", exp_rx.size(), 0);
        check("fifo_empty", {31'h0, tx_empty}, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
